// File: rtl/scroll_sweep_engine.sv
// scroll_sweep_engine: wrap-around vertical scroll offset stepped by a prescaled tick, re-sweeping the full screen after each change.
// Define SCROLL_BIDIR_EN to honour dir (decrement); otherwise the offset always increments.
module scroll_sweep_engine #(
  parameter int XSCREEN    = 160,
  parameter int YSCREEN    = 120,
  parameter int XW         = 8,
  parameter int YW         = 7,
  parameter int BASE_TICKS = 25000000,
  parameter int STEP       = 1
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          enable,
  input  logic [1:0]    speed_sel,
  input  logic          dir,
  output logic [YW-1:0] offset,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [YW-1:0] src_y,
  output logic          plot,
  output logic          busy,
  output logic          frame_done
);
  localparam int PW = $clog2(BASE_TICKS + 1);
  localparam logic [YW:0] YS  = (YW+1)'(YSCREEN);
  localparam logic [YW:0] STP = (YW+1)'(STEP);
  typedef enum logic [1:0] {INIT, IDLE, SWEEP} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_cnt, w_lim;
  logic [YW-1:0] w_new;
  logic [YW:0] w_o;
  logic r_pend, w_tick, w_step, w_start, w_last;
  assign w_lim   = (PW'(BASE_TICKS) >> speed_sel) - PW'(1);
  assign w_tick  = enable && r_cnt >= w_lim;
  assign w_step  = r_state == IDLE && (w_tick || r_pend);
  assign w_start = r_state == INIT || w_step;
  assign w_last  = x == XW'(XSCREEN-1) && y == YW'(YSCREEN-1);
  assign w_o     = {1'b0, offset};
`ifdef SCROLL_BIDIR_EN
  assign w_new = dir ? YW'(w_o >= STP ? w_o - STP : w_o + YS - STP)
                     : YW'(w_o + STP >= YS ? w_o + STP - YS : w_o + STP);
`else
  logic w_unused_dir;
  assign w_unused_dir = dir;
  assign w_new = YW'(w_o + STP >= YS ? w_o + STP - YS : w_o + STP);
`endif
  always_comb begin
    w_next = r_state;
    w_next = r_state == INIT ? SWEEP : r_state == IDLE ? (w_step ? SWEEP : IDLE) : (w_last ? IDLE : SWEEP);
  end
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= INIT;
    else r_state <= w_next;
  end
  // pending is one deep: any tick outside an IDLE step is remembered once
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      offset     <= '0;
      x          <= '0;
      y          <= '0;
      src_y      <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_cnt      <= (!enable || w_tick) ? '0 : r_cnt + 1'b1;
      frame_done <= 1'b0;
      if (w_step) r_pend <= 1'b0;
      else if (w_tick) r_pend <= 1'b1;
      if (w_start) begin
        if (w_step) offset <= w_new;
        x     <= '0;
        y     <= '0;
        src_y <= w_step ? w_new : offset;
        plot  <= 1'b1;
        busy  <= 1'b1;
      end else if (r_state == SWEEP) begin
        if (w_last) begin
          plot       <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else if (x == XW'(XSCREEN-1)) begin
          x     <= '0;
          y     <= y + 1'b1;
          src_y <= src_y == YW'(YSCREEN-1) ? '0 : src_y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_scroll_sweep_engine.sv
// tb_scroll_sweep_engine: scoreboard bench on a 4x5 screen with a 40-cycle base tick.
module tb_scroll_sweep_engine;
  localparam int XS = 4;
  localparam int YS = 5;
`ifdef SCROLL_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif
  typedef struct {int c; int off; int x; int y; int sy;} pix_t;
  logic clk = 1'b0, resetn = 1'b0, enable = 1'b0, dir = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic [6:0] offset, y, src_y;
  logic [7:0] x;
  logic plot, busy, frame_done;
  int cyc = 0, n_vec = 0, n_err = 0;
  pix_t pq[$];
  int fq[$];
  pix_t p;
  int fc;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  scroll_sweep_engine #(.XSCREEN(XS), .YSCREEN(YS), .XW(8), .YW(7), .BASE_TICKS(40), .STEP(1)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .speed_sel(speed_sel), .dir(dir),
    .offset(offset), .x(x), .y(y), .src_y(src_y), .plot(plot), .busy(busy), .frame_done(frame_done)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push_sweep(int c0, int off, int n);
    for (int k = 0; k < n; k++) pq.push_back('{c0 + k, off, k % XS, k / XS, (k / XS + off) % YS});
  endtask
  task automatic at(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      if (pq.size() == 0) check("unexpected_plot", 1, 0);
      else begin
        p = pq.pop_front();
        check("pix_cycle", cyc, p.c);
        check("offset", offset, p.off);
        check("x", x, p.x);
        check("y", y, p.y);
        check("src_y", src_y, p.sy);
        check("busy", busy, 1);
      end
    end
    if (frame_done === 1'b1) begin
      if (fq.size() == 0) check("unexpected_frame_done", 1, 0);
      else begin
        fc = fq.pop_front();
        check("frame_done_cycle", cyc, fc);
        check("busy_at_done", busy, 0);
      end
    end
  end
  initial begin
    at(2);
    check("rst_offset", offset, 0);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_src_y", src_y, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    at(3);
    resetn = 1'b1;
    push_sweep(4, 0, XS * YS);
    fq.push_back(24);
    at(40);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_sweep(80 + 40 * i, (i + 1) % YS, XS * YS);
      fq.push_back(100 + 40 * i);
    end
    at(304);
    enable = 1'b0;
    at(310);
    speed_sel = 2'd3;
    enable = 1'b1;
    push_sweep(315, 2, XS * YS);
    fq.push_back(335);
    push_sweep(336, 3, XS * YS);
    fq.push_back(356);
    push_sweep(357, 4, 8);
    at(356);
    enable = 1'b0;
    at(364);
    resetn = 1'b0;
    speed_sel = 2'd0;
    at(365);
    check("abort_plot", plot, 0);
    check("abort_offset", offset, 0);
    check("abort_busy", busy, 0);
    at(368);
    resetn = 1'b1;
    dir = 1'b1;
    push_sweep(369, 0, XS * YS);
    fq.push_back(389);
    at(400);
    enable = 1'b1;
    push_sweep(440, BIDIR ? 4 : 1, XS * YS);
    fq.push_back(460);
    push_sweep(480, BIDIR ? 3 : 2, XS * YS);
    fq.push_back(500);
    at(505);
    enable = 1'b0;
    at(520);
    check("pixels_left", pq.size(), 0);
    check("frame_done_left", fq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
